// File: rtl/output_buffer_mp.sv
// ============================================================================
// output_buffer_mp
// ----------------------------------------------------------------------------
// Memory-mapped output peripheral: red/green LED registers, a bank of
// 7-segment digit registers and a small HD44780-style LCD write sequencer.
//
// Address map (byte addresses within the output region):
//   0x0000        LEDR (byte-lane writable, LEDR_W bits)
//   0x0010        LEDG (byte-lane writable, LEDG_W bits)
//   0x0020+k      HEX k, k < N_HEX (7 bits, lane 0 only)
//   0x0030        LCD command: wr {rs, data} starts a sequence when idle
//   0x0034        LCD status: rd {overrun, busy}; wr bit1 clears overrun
//   0x0040        blink mask (only with OUTPUT_BUFFER_BLINK_EN)
//   anything else reads 0, writes ignored
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_addr      byte address
//   i_wr_data   write data
//   i_wr_en     write strobe
//   i_bmask     byte-lane enables
//   o_ld_data   combinational read data
//   o_io_ledr   red LEDs (blink-masked when blink is enabled)
//   o_io_ledg   green LEDs
//   o_io_hex    7-segment digits, digit k at [7k+6:7k]
//   o_lcd_data  LCD data bus
//   o_lcd_rs    LCD register select
//   o_lcd_en    LCD enable strobe (high only in PULSE)
//   o_lcd_busy  LCD sequencer not idle
//
// Build option:
//   OUTPUT_BUFFER_BLINK_EN  adds the blink mask register, prescaler and
//                           phase; without it o_io_ledr is the raw register.
// ============================================================================
module output_buffer_mp #(
    parameter int LEDR_W    = 17,
    parameter int LEDG_W    = 8,
    parameter int N_HEX     = 8,
    parameter int LCD_SETUP = 2,
    parameter int LCD_PULSE = 12,
    parameter int LCD_HOLD  = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [15:0]          i_addr,
    input  logic [31:0]          i_wr_data,
    input  logic                 i_wr_en,
    input  logic [3:0]           i_bmask,
    output logic [31:0]          o_ld_data,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*N_HEX-1:0]   o_io_hex,
    output logic [7:0]           o_lcd_data,
    output logic                 o_lcd_rs,
    output logic                 o_lcd_en,
    output logic                 o_lcd_busy
);

    localparam logic [15:0] ADDR_LEDR  = 16'h0000;
    localparam logic [15:0] ADDR_LEDG  = 16'h0010;
    localparam logic [15:0] ADDR_LCD   = 16'h0030;
    localparam logic [15:0] ADDR_STAT  = 16'h0034;
    localparam logic [15:0] ADDR_BLINK = 16'h0040;

    // One shared down-counter times all LCD phases, so it is sized for the
    // longest of them (it is loaded with length-1).
    localparam int CNT_MAX = (LCD_SETUP > LCD_PULSE)
                           ? ((LCD_SETUP > LCD_HOLD) ? LCD_SETUP : LCD_HOLD)
                           : ((LCD_PULSE > LCD_HOLD) ? LCD_PULSE : LCD_HOLD);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (LEDR_W < 1 || LEDR_W > 32 || LEDG_W < 1 || LEDG_W > 32 ||
        N_HEX < 1 || N_HEX > 8 || LCD_SETUP < 1 || LCD_PULSE < 1 ||
        LCD_HOLD < 1 || BLINK_DIV < 2) begin : g_param_check
        $error("output_buffer_mp: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_t;

    logic [31:0]        lane_mask;
    logic               hit_ledr, hit_ledg, hit_hex, hit_lcd, hit_stat, hit_blink;
    logic [LEDR_W-1:0]  ledr;
    logic [LEDG_W-1:0]  ledg;
    logic [6:0]         hex_reg [N_HEX];
    logic [7:0]         lcd_data;
    logic               lcd_rs;
    logic               overrun;
    lcd_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               lcd_cmd, lcd_accept, lcd_overrun_evt, overrun_clr;
    logic [31:0]        blink_rd;

    // Byte-lane enables expanded to a per-bit mask.
    assign lane_mask = {{8{i_bmask[3]}}, {8{i_bmask[2]}},
                        {8{i_bmask[1]}}, {8{i_bmask[0]}}};

    assign hit_ledr  = (i_addr == ADDR_LEDR);
    assign hit_ledg  = (i_addr == ADDR_LEDG);
    // HEX window is 0x0020..0x0027; only the first N_HEX slots exist.
    assign hit_hex   = (i_addr[15:3] == 13'h0004) && ({29'd0, i_addr[2:0]} < N_HEX);
    assign hit_lcd   = (i_addr == ADDR_LCD);
    assign hit_stat  = (i_addr == ADDR_STAT);
    assign hit_blink = (i_addr == ADDR_BLINK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr <= '0;
            ledg <= '0;
        end else if (i_wr_en) begin
            if (hit_ledr) begin
                ledr <= (ledr & ~lane_mask[LEDR_W-1:0]) |
                        (i_wr_data[LEDR_W-1:0] & lane_mask[LEDR_W-1:0]);
            end
            if (hit_ledg) begin
                ledg <= (ledg & ~lane_mask[LEDG_W-1:0]) |
                        (i_wr_data[LEDG_W-1:0] & lane_mask[LEDG_W-1:0]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_HEX; k++) begin
                hex_reg[k] <= '0;
            end
        end else if (i_wr_en && hit_hex && i_bmask[0]) begin
            for (int k = 0; k < N_HEX; k++) begin
                if (i_addr[2:0] == 3'(k)) begin
                    hex_reg[k] <= i_wr_data[6:0];
                end
            end
        end
    end

    for (genvar k = 0; k < N_HEX; k++) begin : g_hex_out
        assign o_io_hex[7*k +: 7] = hex_reg[k];
    end

    assign o_io_ledg = ledg;

    // LCD sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign lcd_cmd = i_wr_en && hit_lcd && i_bmask[0];

    // Next state, counter reload and strobes. A command is only taken in
    // IDLE; any command seen in another state (including the last HOLD
    // cycle) is an overrun.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        lcd_accept      = 1'b0;
        lcd_overrun_evt = 1'b0;
        o_lcd_en        = 1'b0;
        o_lcd_busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                o_lcd_busy = 1'b0;
                if (lcd_cmd) begin
                    lcd_accept = 1'b1;
                    state_nxt  = ST_SETUP;
                    cnt_nxt    = CNT_W'(LCD_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = CNT_W'(LCD_PULSE - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                o_lcd_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(LCD_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (lcd_cmd && (state != ST_IDLE)) begin
            lcd_overrun_evt = 1'b1;
        end
    end

    assign overrun_clr = i_wr_en && hit_stat && i_bmask[0] && i_wr_data[1];

    // Command latches and the sticky overrun flag (set beats clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (lcd_accept) begin
                lcd_data <= i_wr_data[7:0];
                lcd_rs   <= i_wr_data[8];
            end
            if (lcd_overrun_evt) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign o_lcd_data = lcd_data;
    assign o_lcd_rs   = lcd_rs;

`ifdef OUTPUT_BUFFER_BLINK_EN
    localparam int PRE_W = $clog2(BLINK_DIV);

    logic [LEDR_W-1:0] blink_mask;
    logic [PRE_W-1:0]  prescaler;
    logic              phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_mask <= '0;
        end else if (i_wr_en && hit_blink) begin
            blink_mask <= (blink_mask & ~lane_mask[LEDR_W-1:0]) |
                          (i_wr_data[LEDR_W-1:0] & lane_mask[LEDR_W-1:0]);
        end
    end

    // Free-running prescaler; phase flips each time it wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler <= '0;
            phase     <= 1'b0;
        end else if (prescaler == PRE_W'(BLINK_DIV - 1)) begin
            prescaler <= '0;
            phase     <= ~phase;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign o_io_ledr = ledr & ~(blink_mask & {LEDR_W{phase}});
    assign blink_rd  = 32'(blink_mask);
`else
    assign o_io_ledr = ledr;
    assign blink_rd  = '0;
`endif

    // Read mux; LEDR returns the stored value, not the blinked output.
    always_comb begin
        o_ld_data = '0;
        if (hit_ledr) begin
            o_ld_data = 32'(ledr);
        end else if (hit_ledg) begin
            o_ld_data = 32'(ledg);
        end else if (hit_hex) begin
            for (int k = 0; k < N_HEX; k++) begin
                if (i_addr[2:0] == 3'(k)) begin
                    o_ld_data = {25'd0, hex_reg[k]};
                end
            end
        end else if (hit_lcd) begin
            o_ld_data = {23'd0, lcd_rs, lcd_data};
        end else if (hit_stat) begin
            o_ld_data = {30'd0, overrun, o_lcd_busy};
        end else if (hit_blink) begin
            o_ld_data = blink_rd;
        end
    end

    // Upper data/lane bits are legitimately unused for narrow registers.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_wr_data, lane_mask};

endmodule

// File: tb/tb_output_buffer_mp.sv
// ============================================================================
// tb_output_buffer_mp
// ----------------------------------------------------------------------------
// Self-checking bench for output_buffer_mp. Expected read values and LCD pin
// timelines are queued when stimulus is issued and compared when the DUT
// output is sampled.
// ============================================================================
module tb_output_buffer_mp;

    localparam int LEDR_W    = 17;
    localparam int LEDG_W    = 8;
    localparam int N_HEX     = 8;
    localparam int LCD_SETUP = 2;
    localparam int LCD_PULSE = 12;
    localparam int LCD_HOLD  = 2;
    localparam int BLINK_DIV = 4;
    localparam int LCD_TOTAL = LCD_SETUP + LCD_PULSE + LCD_HOLD;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic [15:0]          i_addr = '0;
    logic [31:0]          i_wr_data = '0;
    logic                 i_wr_en = 1'b0;
    logic [3:0]           i_bmask = '0;
    logic [31:0]          o_ld_data;
    logic [LEDR_W-1:0]    o_io_ledr;
    logic [LEDG_W-1:0]    o_io_ledg;
    logic [7*N_HEX-1:0]   o_io_hex;
    logic [7:0]           o_lcd_data;
    logic                 o_lcd_rs;
    logic                 o_lcd_en;
    logic                 o_lcd_busy;

    output_buffer_mp #(
        .LEDR_W    (LEDR_W),
        .LEDG_W    (LEDG_W),
        .N_HEX     (N_HEX),
        .LCD_SETUP (LCD_SETUP),
        .LCD_PULSE (LCD_PULSE),
        .LCD_HOLD  (LCD_HOLD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wr_en    (i_wr_en),
        .i_bmask    (i_bmask),
        .o_ld_data  (o_ld_data),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_hex   (o_io_hex),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_busy (o_lcd_busy)
    );

    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    string       tag_q[$];
    logic [15:0] addr_q[$];
    logic [31:0] exp_q[$];
    logic [10:0] lcd_q[$];

    logic [LEDR_W-1:0]  ledr_model = '0;
    logic [LEDG_W-1:0]  ledg_model = '0;
    logic [7*N_HEX-1:0] hex_model  = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] laneMask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // One register write: driven on a falling edge, taken at the next rise,
    // released on the following falling edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] bmask);
        @(negedge i_clk);
        i_addr    = addr;
        i_wr_data = data;
        i_bmask   = bmask;
        i_wr_en   = 1'b1;
        @(negedge i_clk);
        i_wr_en   = 1'b0;
        i_bmask   = '0;
    endtask

    task automatic expectRead(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        tag_q.push_back(tag);
        addr_q.push_back(addr);
        exp_q.push_back(exp);
    endtask

    task automatic drainReads();
        string       t;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            t      = tag_q.pop_front();
            e      = exp_q.pop_front();
            i_addr = addr_q.pop_front();
            #1;
            checkOutput(t, o_ld_data, e);
        end
    endtask

    function automatic logic [10:0] lcdPins();
        return {o_lcd_busy, o_lcd_en, o_lcd_rs, o_lcd_data};
    endfunction

    // Full command: queue the expected pin timeline for cycles 1..TOTAL+1
    // after the accepting edge, then issue and compare each cycle.
    task automatic lcdSequence(input string name, input logic [8:0] cmd);
        logic        b, e;
        logic [10:0] w;
        for (int c = 1; c <= LCD_TOTAL + 1; c++) begin
            b = (c <= LCD_TOTAL);
            e = (c > LCD_SETUP) && (c <= LCD_SETUP + LCD_PULSE);
            lcd_q.push_back({b, e, cmd[8], cmd[7:0]});
        end
        @(negedge i_clk);
        i_addr    = 16'h0030;
        i_wr_data = {23'd0, cmd};
        i_bmask   = 4'b0001;
        i_wr_en   = 1'b1;
        for (int c = 1; c <= LCD_TOTAL + 1; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_wr_en = 1'b0;
                i_bmask = '0;
            end
            w = lcd_q.pop_front();
            checkOutput($sformatf("%s_c%0d", name, c), 32'(lcdPins()), 32'(w));
        end
    endtask

    task automatic issueCmd(input logic [8:0] cmd);
        @(negedge i_clk);
        i_addr    = 16'h0030;
        i_wr_data = {23'd0, cmd};
        i_bmask   = 4'b0001;
        i_wr_en   = 1'b1;
    endtask

    task automatic waitIdle(input string tag);
        for (int n = 0; n < 100 && o_lcd_busy; n++) begin
            @(negedge i_clk);
        end
        checkOutput(tag, 32'(o_lcd_busy), 32'd0);
    endtask

`ifdef OUTPUT_BUFFER_BLINK_EN
    logic [LEDR_W-1:0] samp [32];
`endif

    initial begin
        $display("[TB] start");
        // ---------------- reset state ----------------
        repeat (2) @(negedge i_clk);
        i_addr = 16'h0034;
        #1;
        checkOutput("rst_ledr", 32'(o_io_ledr), 32'd0);
        checkOutput("rst_ledg", 32'(o_io_ledg), 32'd0);
        checkOutput("rst_hex_lo", o_io_hex[31:0], 32'd0);
        checkOutput("rst_lcd", 32'(lcdPins()), 32'd0);
        checkOutput("rst_status", o_ld_data, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // ---------------- LED byte lanes ----------------
        applyStimulus(16'h0000, 32'hDEADBEEF, 4'b0101);
        ledr_model = (ledr_model & ~LEDR_W'(laneMask(4'b0101))) |
                     LEDR_W'(32'hDEADBEEF & laneMask(4'b0101));
        checkOutput("ledr_out1", 32'(o_io_ledr), 32'(ledr_model));
        expectRead("ledr_rd1", 16'h0000, 32'h0001_00EF);
        drainReads();

        applyStimulus(16'h0000, 32'h12345678, 4'b1010);
        ledr_model = (ledr_model & ~LEDR_W'(laneMask(4'b1010))) |
                     LEDR_W'(32'h12345678 & laneMask(4'b1010));
        expectRead("ledr_rd2", 16'h0000, 32'(ledr_model));
        drainReads();

        applyStimulus(16'h0010, 32'hA5A5A5C3, 4'b0001);
        ledg_model = 8'hC3;
        applyStimulus(16'h0010, 32'hFFFFFF11, 4'b1110);
        checkOutput("ledg_out", 32'(o_io_ledg), 32'(ledg_model));
        expectRead("ledg_rd", 16'h0010, 32'h0000_00C3);
        expectRead("unmapped_rd", 16'h0004, 32'd0);
        drainReads();

        // ---------------- HEX digits ----------------
        applyStimulus(16'h0023, 32'h0000007F, 4'b0001);
        hex_model[7*3 +: 7] = 7'h7F;
        applyStimulus(16'h0028, 32'h0000007F, 4'b0001);
        applyStimulus(16'h0020, 32'h00000055, 4'b1110);
        applyStimulus(16'h0027, 32'h00ABCD95, 4'b0001);
        hex_model[7*7 +: 7] = 7'h15;
        checkOutput("hex_out_lo", o_io_hex[31:0], hex_model[31:0]);
        checkOutput("hex_out_hi", 32'(o_io_hex[7*N_HEX-1:32]), 32'(hex_model[7*N_HEX-1:32]));
        expectRead("hex3_rd", 16'h0023, 32'h7F);
        expectRead("hex8_rd", 16'h0028, 32'd0);
        expectRead("hex0_rd", 16'h0020, 32'd0);
        expectRead("hex7_rd", 16'h0027, 32'h15);
        drainReads();

        // ---------------- LCD full command ----------------
        lcdSequence("lcd141", 9'h141);
        expectRead("lcd_latch_rd", 16'h0030, 32'h141);
        expectRead("lcd_status_idle", 16'h0034, 32'd0);
        drainReads();

        // ---------------- second write during PULSE ----------------
        issueCmd(9'h062);
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_wr_en = 1'b0;
            end
        end
        checkOutput("pulse_en", 32'(o_lcd_en), 32'd1);
        i_wr_data = 32'h0000_01AA;
        i_bmask   = 4'b0001;
        i_wr_en   = 1'b1;
        @(negedge i_clk);
        i_wr_en = 1'b0;
        checkOutput("ovr_data_kept", 32'(o_lcd_data), 32'h62);
        expectRead("ovr_latch_rd", 16'h0030, 32'h062);
        expectRead("ovr_status", 16'h0034, 32'h3);
        drainReads();
        applyStimulus(16'h0034, 32'h2, 4'b0001);
        waitIdle("ovr_idle");
        expectRead("ovr_cleared", 16'h0034, 32'd0);
        drainReads();

        // ---------------- command on the last HOLD cycle ----------------
        issueCmd(9'h141);
        for (int c = 1; c <= LCD_TOTAL; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_wr_en = 1'b0;
            end
        end
        i_wr_data = 32'h0000_0155;
        i_bmask   = 4'b0001;
        i_wr_en   = 1'b1;
        @(negedge i_clk);
        i_wr_en = 1'b0;
        checkOutput("hold_drop_busy", 32'(o_lcd_busy), 32'd0);
        expectRead("hold_drop_latch", 16'h0030, 32'h141);
        expectRead("hold_drop_status", 16'h0034, 32'h2);
        drainReads();
        applyStimulus(16'h0034, 32'h2, 4'b0001);
        expectRead("hold_clear", 16'h0034, 32'd0);
        drainReads();

        // ---------------- blink ----------------
`ifdef OUTPUT_BUFFER_BLINK_EN
        begin
            int  first;
            logic [LEDR_W-1:0] e;
            applyStimulus(16'h0000, 32'h0001FFFF, 4'b0111);
            applyStimulus(16'h0040, 32'h00000001, 4'b0111);
            expectRead("blink_mask_rd", 16'h0040, 32'h1);
            drainReads();
            for (int j = 0; j < 32; j++) begin
                @(negedge i_clk);
                samp[j] = o_io_ledr;
            end
            first = -1;
            for (int j = 1; j < 9; j++) begin
                if (first < 0 && samp[j] != samp[j-1]) begin
                    first = j;
                end
            end
            checkOutput("blink_toggle_found", 32'(first > 0), 32'd1);
            if (first > 0) begin
                checkOutput("blink_pair", 32'(samp[first] | samp[first-1]), 32'h1FFFF);
                checkOutput("blink_diff", 32'(samp[first] ^ samp[first-1]), 32'h1);
                for (int j = first; j < first + 16; j++) begin
                    e = (((j - first) / BLINK_DIV) % 2 == 0) ? samp[first] : samp[first-1];
                    checkOutput($sformatf("blink_s%0d", j), 32'(samp[j]), 32'(e));
                end
            end
        end
`else
        applyStimulus(16'h0040, 32'hFFFFFFFF, 4'b1111);
        checkOutput("noblink_ledr", 32'(o_io_ledr), 32'(ledr_model));
        expectRead("noblink_rd", 16'h0040, 32'd0);
        drainReads();
`endif

        // ---------------- reset during PULSE ----------------
        issueCmd(9'h141);
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            if (c == 1) begin
                i_wr_en = 1'b0;
            end
        end
        checkOutput("pre_rst_en", 32'(o_lcd_en), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_en", 32'(o_lcd_en), 32'd0);
        checkOutput("rst_mid_busy", 32'(o_lcd_busy), 32'd0);
        checkOutput("rst_mid_ledr", 32'(o_io_ledr), 32'd0);
        expectRead("rst_mid_lcd_rd", 16'h0030, 32'd0);
        drainReads();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        lcdSequence("lcd023", 9'h023);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled bench.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
